// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Function : Forwarding, stall and multi-cycle scoreboard for the 5-stage core.
//            Optional stall counter enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int AW   = 5,
    parameter int LATW = 4,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs_d,
    input  logic [AW-1:0]   rt_d,
    input  logic            branch_d,
    input  logic            mc_req_d,
    input  logic [AW-1:0]   rse_ex,
    input  logic [AW-1:0]   rte_ex,
    input  logic            regwrite_ex,
    input  logic            memtoreg_ex,
    input  logic [AW-1:0]   writereg_ex,
    input  logic            regwrite_mem,
    input  logic            memtoreg_mem,
    input  logic [AW-1:0]   writereg_mem,
    input  logic            regwrite_wb,
    input  logic [AW-1:0]   writereg_wb,
    input  logic            mc_start_ex,
    input  logic [AW-1:0]   mc_dest_ex,
    input  logic [LATW-1:0] mc_lat_ex,
    input  logic            perf_clr,
    output logic [1:0]      forward_a_e,
    output logic [1:0]      forward_b_e,
    output logic            forward_a_d,
    output logic            forward_b_d,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_e,
    output logic            mc_busy,
    output logic            mc_done,
    output logic            mc_err,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [LATW-1:0] C_LAT_ONE = LATW'(1);

    logic [LATW-1:0] count_q, count_d;
    logic [AW-1:0]   mc_dest_q, mc_dest_d;
    logic            mc_err_q, mc_err_d;

    logic            count_gt1;
    logic            lw_stall;
    logic            br_stall;
    logic            mc_stall;
    logic            stall_any;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] ex_select(input logic [AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (mc_done && reg_hit(src, mc_dest_q)) begin
            sel = 2'b11;
        end else if (regwrite_mem && reg_hit(src, writereg_mem)) begin
            sel = 2'b10;
        end else if (regwrite_wb && reg_hit(src, writereg_wb)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign mc_busy   = (count_q != '0);
    assign mc_done   = (count_q == C_LAT_ONE);
    assign count_gt1 = (count_q > C_LAT_ONE);
    assign mc_err    = mc_err_q;

    assign forward_a_e = ex_select(rse_ex);
    assign forward_b_e = ex_select(rte_ex);
    assign forward_a_d = regwrite_mem && reg_hit(rs_d, writereg_mem);
    assign forward_b_d = regwrite_mem && reg_hit(rt_d, writereg_mem);

    assign lw_stall = memtoreg_ex && regwrite_ex &&
                      (reg_hit(rs_d, writereg_ex) || reg_hit(rt_d, writereg_ex));

    assign br_stall = branch_d &&
                      ((regwrite_ex  && (reg_hit(rs_d, writereg_ex)  || reg_hit(rt_d, writereg_ex))) ||
                       (memtoreg_mem && (reg_hit(rs_d, writereg_mem) || reg_hit(rt_d, writereg_mem))));

    // In the DONE cycle the register file already holds the result, so only
    // count_q > 1 keeps a decode reader of mc_dest_q waiting.
    assign mc_stall = (mc_req_d && (mc_busy || mc_start_ex)) ||
                      (count_gt1 && (reg_hit(rs_d, mc_dest_q) || reg_hit(rt_d, mc_dest_q))) ||
                      (mc_start_ex && (reg_hit(rs_d, mc_dest_ex) || reg_hit(rt_d, mc_dest_ex)));

    assign stall_any = lw_stall || br_stall || mc_stall;
    assign stall_f   = stall_any;
    assign stall_d   = stall_any;
    assign flush_e   = stall_any;

    always_comb begin
        count_d   = count_q;
        mc_dest_d = mc_dest_q;
        mc_err_d  = mc_err_q;
        if (count_gt1) begin
            count_d = count_q - C_LAT_ONE;
            if (mc_start_ex) begin
                mc_err_d = 1'b1;
            end
        end else if (mc_start_ex) begin
            count_d   = (mc_lat_ex == '0) ? C_LAT_ONE : mc_lat_ex;
            mc_dest_d = mc_dest_ex;
        end else if (mc_done) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            mc_dest_q <= '0;
            mc_err_q  <= 1'b0;
        end else begin
            count_q   <= count_d;
            mc_dest_q <= mc_dest_d;
            mc_err_q  <= mc_err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (stall_any && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Function : Directed bench for hazard_scoreboard with a cycle-stamped model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int AW      = 5;
    localparam int LATW    = 4;
    localparam int CNTW    = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [AW-1:0]   rs_d, rt_d, rse_ex, rte_ex, writereg_ex, writereg_mem, writereg_wb, mc_dest_ex;
    logic            branch_d, mc_req_d, regwrite_ex, memtoreg_ex, regwrite_mem, memtoreg_mem;
    logic            regwrite_wb, mc_start_ex, perf_clr;
    logic [LATW-1:0] mc_lat_ex;
    logic [1:0]      forward_a_e, forward_b_e;
    logic            forward_a_d, forward_b_d, stall_f, stall_d, flush_e;
    logic            mc_busy, mc_done, mc_err;
    logic [CNTW-1:0] stall_cnt;

    hazard_scoreboard #(.AW(AW), .LATW(LATW), .CNTW(CNTW)) dut (
        .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .mc_req_d(mc_req_d), .rse_ex(rse_ex), .rte_ex(rte_ex), .regwrite_ex(regwrite_ex),
        .memtoreg_ex(memtoreg_ex), .writereg_ex(writereg_ex), .regwrite_mem(regwrite_mem),
        .memtoreg_mem(memtoreg_mem), .writereg_mem(writereg_mem), .regwrite_wb(regwrite_wb),
        .writereg_wb(writereg_wb), .mc_start_ex(mc_start_ex), .mc_dest_ex(mc_dest_ex),
        .mc_lat_ex(mc_lat_ex), .perf_clr(perf_clr), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e), .mc_busy(mc_busy),
        .mc_done(mc_done), .mc_err(mc_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the in-flight op is a window of absolute cycle numbers.
    int          cyc     = 0;
    bit          m_valid = 0;
    int          m_end   = 0;
    logic [AW-1:0] m_dest = '0;
    bit          m_err   = 0;
    int          m_cnt   = 0;

    function automatic bit hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic bit m_busy();
        return m_valid && (cyc <= m_end);
    endfunction

    function automatic bit m_done();
        return m_valid && (cyc == m_end);
    endfunction

    function automatic int exp_fwd(input logic [AW-1:0] op);
        if (m_done() && hit(op, m_dest)) return 3;
        if (regwrite_mem && hit(op, writereg_mem)) return 2;
        if (regwrite_wb && hit(op, writereg_wb)) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit d_on_ex, d_on_mem, d_on_mc, d_on_new;
        d_on_ex  = hit(rs_d, writereg_ex)  || hit(rt_d, writereg_ex);
        d_on_mem = hit(rs_d, writereg_mem) || hit(rt_d, writereg_mem);
        d_on_mc  = hit(rs_d, m_dest)       || hit(rt_d, m_dest);
        d_on_new = hit(rs_d, mc_dest_ex)   || hit(rt_d, mc_dest_ex);
        if (memtoreg_ex && regwrite_ex && d_on_ex) return 1;
        if (branch_d && ((regwrite_ex && d_on_ex) || (memtoreg_mem && d_on_mem))) return 1;
        if (mc_req_d && (m_busy() || mc_start_ex)) return 1;
        if (m_busy() && !m_done() && d_on_mc) return 1;
        if (mc_start_ex && d_on_new) return 1;
        return 0;
    endfunction

    function automatic int exp_cnt();
`ifdef HAZARD_PERF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        m_valid = 0;
        m_end   = 0;
        m_dest  = '0;
        m_err   = 0;
        m_cnt   = 0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            if (perf_clr) m_cnt = 0;
            else if (exp_stall() && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (mc_start_ex) begin
                if (!m_busy() || m_done()) begin
                    m_valid = 1;
                    m_end   = cyc + ((mc_lat_ex == 0) ? 1 : int'(mc_lat_ex));
                    m_dest  = mc_dest_ex;
                end else begin
                    m_err = 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("fwd_a_e",   32'(forward_a_e), 32'(exp_fwd(rse_ex)));
        check("fwd_b_e",   32'(forward_b_e), 32'(exp_fwd(rte_ex)));
        check("fwd_a_d",   32'(forward_a_d), 32'(regwrite_mem && hit(rs_d, writereg_mem)));
        check("fwd_b_d",   32'(forward_b_d), 32'(regwrite_mem && hit(rt_d, writereg_mem)));
        check("stall_f",   32'(stall_f),     32'(exp_stall()));
        check("stall_d",   32'(stall_d),     32'(exp_stall()));
        check("flush_e",   32'(flush_e),     32'(exp_stall()));
        check("mc_busy",   32'(mc_busy),     32'(m_busy()));
        check("mc_done",   32'(mc_done),     32'(m_done()));
        check("mc_err",    32'(mc_err),      32'(m_err));
        check("stall_cnt", 32'(stall_cnt),   32'(exp_cnt()));
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clr_in();
        rs_d = '0; rt_d = '0; branch_d = 0; mc_req_d = 0; rse_ex = '0; rte_ex = '0;
        regwrite_ex = 0; memtoreg_ex = 0; writereg_ex = '0;
        regwrite_mem = 0; memtoreg_mem = 0; writereg_mem = '0;
        regwrite_wb = 0; writereg_wb = '0;
        mc_start_ex = 0; mc_dest_ex = '0; mc_lat_ex = '0; perf_clr = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rst_n = 0;
        settle();
        check("rst_busy", 32'(mc_busy), 0);
        check("rst_done", 32'(mc_done), 0);
        check("rst_err",  32'(mc_err), 0);
        check("rst_cnt",  32'(stall_cnt), 0);
        adv();
        rst_n = 1;

        // EX forwarding priority
        rse_ex = 5; rte_ex = 5; regwrite_mem = 1; writereg_mem = 5; regwrite_wb = 1; writereg_wb = 5;
        settle();
        check("fwd_mem_over_wb", 32'(forward_a_e), 2);
        adv();
        rse_ex = 0;
        settle();
        check("fwd_r0", 32'(forward_a_e), 0);
        check("fwd_b_mem", 32'(forward_b_e), 2);
        adv();
        regwrite_mem = 0; rse_ex = 5;
        settle();
        check("fwd_wb", 32'(forward_a_e), 1);

        // Load-use
        adv(); clr_in();
        memtoreg_ex = 1; regwrite_ex = 1; writereg_ex = 8; rt_d = 8;
        settle();
        check("lu_stall_f", 32'(stall_f), 1);
        check("lu_stall_d", 32'(stall_d), 1);
        check("lu_flush_e", 32'(flush_e), 1);
        adv();
        memtoreg_ex = 0; regwrite_ex = 0; writereg_ex = 0;
        regwrite_mem = 1; memtoreg_mem = 1; writereg_mem = 8;
        settle();
        check("lu_release", 32'(stall_d), 0);

        // Branch
        adv(); clr_in();
        branch_d = 1; rs_d = 3; regwrite_ex = 1; writereg_ex = 3;
        settle();
        check("br_stall", 32'(stall_d), 1);
        adv();
        regwrite_ex = 0; writereg_ex = 0; regwrite_mem = 1; memtoreg_mem = 0; writereg_mem = 3;
        settle();
        check("br_release", 32'(stall_f), 0);
        check("br_fwd_d", 32'(forward_a_d), 1);

        // Multi-cycle latency 4
        adv(); clr_in();
        mc_start_ex = 1; mc_lat_ex = 4; mc_dest_ex = 9; rs_d = 9;
        settle();
        adv();
        mc_start_ex = 0; mc_lat_ex = 0; mc_dest_ex = 0;
        for (int i = 1; i <= 3; i++) begin
            settle();
            check("mc_busy_n", 32'(mc_busy), 1);
            check("mc_notdone", 32'(mc_done), 0);
            check("mc_raw_stall", 32'(stall_d), 1);
            adv();
        end
        rse_ex = 9;
        settle();
        check("mc_done4", 32'(mc_done), 1);
        check("mc_release", 32'(stall_d), 0);
        check("mc_fwd11", 32'(forward_a_e), 3);
        adv();
        settle();
        check("mc_idle", 32'(mc_busy), 0);

        // Perf counter saturation and clear
        adv(); clr_in();
        perf_clr = 1;
        settle();
        adv();
        perf_clr = 0; memtoreg_ex = 1; regwrite_ex = 1; writereg_ex = 8; rt_d = 8;
        repeat (5) adv();
        settle();
`ifdef HAZARD_PERF_CNT_EN
        check("perf_sat", 32'(stall_cnt), 3);
`else
        check("perf_tied", 32'(stall_cnt), 0);
`endif
        adv();
        perf_clr = 1;
        adv();
        perf_clr = 0;
        settle();
        check("perf_clr", 32'(stall_cnt), 0);

        // Protocol violation then asynchronous reset mid-count
        adv(); clr_in();
        mc_start_ex = 1; mc_lat_ex = 5; mc_dest_ex = 7;
        adv();
        mc_start_ex = 0;
        adv();
        adv();
        mc_start_ex = 1; mc_lat_ex = 2; mc_dest_ex = 10; rs_d = 7;
        settle();
        check("err_pre", 32'(mc_err), 0);
        adv();
        mc_start_ex = 0;
        settle();
        check("err_set", 32'(mc_err), 1);
        check("err_dest_kept", 32'(stall_d), 1);
        #1 rst_n = 0;
        #1;
        check("rst_mid_busy", 32'(mc_busy), 0);
        check("rst_mid_err", 32'(mc_err), 0);
        check("rst_mid_stall", 32'(stall_d), 0);
        adv();
        rst_n = 1;

        // Back-to-back reload in the DONE cycle, zero latency treated as one
        clr_in();
        mc_start_ex = 1; mc_lat_ex = 2; mc_dest_ex = 4;
        adv();
        mc_start_ex = 0;
        adv();
        mc_start_ex = 1; mc_lat_ex = 0; mc_dest_ex = 6;
        settle();
        check("b2b_done1", 32'(mc_done), 1);
        adv();
        clr_in();
        rse_ex = 6; rte_ex = 4;
        settle();
        check("b2b_done2", 32'(mc_done), 1);
        check("b2b_fwd_a", 32'(forward_a_e), 3);
        check("b2b_fwd_b", 32'(forward_b_e), 0);
        adv();
        clr_in();
        mc_req_d = 1;
        settle();
        check("req_idle", 32'(stall_d), 0);
        #1 mc_start_ex = 1;
        #1 check("req_start", 32'(stall_d), 1);
        adv();
        clr_in();
        settle();
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard unit for the five-stage MIPS core. It supersedes the combinational EX-stage forwarding logic. It adds:
- decode-stage branch-operand forwarding;
- load-use and branch stalls;
- a countdown scoreboard for one in-flight multi-cycle operation (mult/div) with structural and RAW stalls and a result bypass;
- an optional stall performance counter.

It sits beside the datapath and drives the F/D stall enables, the D/E flush, and all forwarding muxes.

## Interface
- `AW`, 5: register-index width.
- `LATW`, 4: multi-cycle latency counter width (max latency 2^LATW-1).
- `CNTW`, 32: stall performance counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rs_d`, `rt_d` in AW: decode source registers.
- `branch_d` in 1: branch in decode.
- `mc_req_d` in 1: multi-cycle instruction in decode.
- `rse_ex`, `rte_ex` in AW: EX source registers.
- `regwrite_ex`, `memtoreg_ex` in 1; `writereg_ex` in AW: EX destination info.
- `regwrite_mem`, `memtoreg_mem` in 1; `writereg_mem` in AW.
- `regwrite_wb` in 1; `writereg_wb` in AW.
- `mc_start_ex` in 1: multi-cycle op issues this cycle.
- `mc_dest_ex` in AW: its destination register.
- `mc_lat_ex` in LATW: its latency in cycles.
- `perf_clr` in 1: synchronous clear of `stall_cnt`.
- `forward_a_e`, `forward_b_e` out 2: EX mux selects.
  - 00 = register file.
  - 01 = WB.
  - 10 = MEM.
  - 11 = multi-cycle result.
- `forward_a_d`, `forward_b_d` out 1: decode branch comparator takes the MEM ALU result.
- `stall_f`, `stall_d`, `flush_e` out 1.
- `mc_busy`, `mc_done`, `mc_err` out 1.
- `stall_cnt` out CNTW.

## Operation
- Register 0 never matches in any comparison below.
- EX forwarding, per operand, in priority order:
  - 11 if `mc_done` and the operand equals `mc_dest_q`.
  - 10 if `regwrite_mem` and the operand equals `writereg_mem`.
  - 01 if `regwrite_wb` and the operand equals `writereg_wb`.
  - 00 otherwise.
- Decode forwarding: `forward_a_d` = `regwrite_mem` & (`rs_d` == `writereg_mem`). `forward_b_d` is the same with `rt_d`.
- Load-use stall (`lw_stall`): `memtoreg_ex` & `regwrite_ex` & `writereg_ex` matches `rs_d` or `rt_d`.
- Branch stall (`br_stall`): `branch_d` and either of:
  - `regwrite_ex` with `writereg_ex` matching `rs_d`/`rt_d`;
  - `memtoreg_mem` with `writereg_mem` matching `rs_d`/`rt_d`.
- Multi-cycle stall (`mc_stall`), any of:
  - `mc_req_d` & (`mc_busy` | `mc_start_ex`);
  - `rs_d`/`rt_d` matches `mc_dest_q` while `count_q` > 1;
  - `rs_d`/`rt_d` matches `mc_dest_ex` while `mc_start_ex`.
- `stall_f` = `stall_d` = `flush_e` = `lw_stall` | `br_stall` | `mc_stall`.
- Scoreboard state: `count_q` (LATW), `mc_dest_q` (AW), `mc_err` (1).
  - IDLE (`count_q` = 0): `mc_start_ex` loads `count_q` = max(`mc_lat_ex`, 1) and `mc_dest_q` = `mc_dest_ex`.
  - BUSY (`count_q` > 1): decrement each cycle.
  - DONE (`count_q` = 1): decrement to 0, unless `mc_start_ex` reloads (back-to-back allowed).
- `mc_busy` = (`count_q` != 0). `mc_done` = (`count_q` == 1), decoded from the register.
- `mc_start_ex` while `count_q` > 1 is a protocol violation:
  - the start is ignored;
  - `mc_err` sets and stays set until reset.
- In the DONE cycle the register file writes first-half, so the decode RAW stall on `mc_dest_q` is already released.

## Timing
- Forwarding and stall outputs are combinational from inputs and state, with zero-cycle latency.
- Latency N: `mc_done` is high exactly N cycles after the `mc_start_ex` edge. `mc_busy` is high for N cycles.
- Reset values, asynchronous on `rst_n` low, including mid-operation:
  - `count_q` = 0, `mc_dest_q` = 0, `mc_err` = 0, `stall_cnt` = 0.
  - Hence `mc_busy` = 0 and `mc_done` = 0.
  - Forward codes 11 and `mc_stall` RAW terms are inactive.
- `stall_cnt` updates on the clock edge:
  - `perf_clr` has priority and clears the counter;
  - otherwise it increments on every cycle with `stall_d` high;
  - it saturates at all-ones and does not wrap.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: the `stall_cnt` register and `perf_clr` logic are built as described above.
- Undefined:
  - `stall_cnt` is tied to 0 and `perf_clr` is ignored;
  - no counter flops are built;
  - all other behaviour is identical.

## Test plan
- Forwarding priority: `rse_ex`=5 with `regwrite_mem`=1, `writereg_mem`=5, `regwrite_wb`=1, `writereg_wb`=5 -> `forward_a_e`=10. With `rse_ex`=0 in the same setup -> 00.
- Load-use: `memtoreg_ex`=1, `regwrite_ex`=1, `writereg_ex`=8, `rt_d`=8 -> `stall_f`=`stall_d`=`flush_e`=1 for one cycle, 0 once EX advances.
- Branch: `branch_d`=1, `rs_d`=3, `regwrite_ex`=1, `writereg_ex`=3 -> stall. Next cycle, with the writer in MEM (`regwrite_mem`=1, `memtoreg_mem`=0) -> no stall and `forward_a_d`=1.
- Multi-cycle: `mc_start_ex` with `mc_lat_ex`=4, `mc_dest_ex`=9 ->
  - `mc_busy` for 4 cycles, `mc_done` on the 4th;
  - `rs_d`=9 stalls in cycles 1-3 and is released in cycle 4;
  - `rse_ex`=9 in cycle 4 -> `forward_a_e`=11.
- Error and reset: `mc_start_ex` at `count_q`=3 -> ignored and `mc_err`=1. Then `rst_n` low mid-count -> all state 0 immediately.
- Perf counter (macro defined, CNTW=2): 5 stall cycles -> `stall_cnt`=3, saturated. Then `perf_clr` -> 0.
